// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive-side timing recovery, measurement and lock monitor
//
// Recovers the pixel position from the hsync/vsync edges of a sampled VGA stream.
// It measures the line period, the frame length and both sync pulse widths, and
// reports any measurement that does not match the nominal timing. Lock is declared
// after LOCK_FRAMES consecutive error-free frames.
//
// Ports:
//   clk_50mhz              rising-edge clock
//   reset_n                asynchronous reset, active low
//   pix_ce                 pixel sample strobe; nothing changes on edges where it is 0
//   hsync, vsync           active-low syncs
//   red, green, blue       4-bit pixel colour
//   pixel_x, pixel_y       recovered position of the most recent sample
//   de                     recovered active video (locked and inside the active area)
//   locked                 timing lock
//   timing_err             one-cycle pulse on a measurement mismatch
//   frame_done             one-cycle pulse at each vsync fall
//   line_len               last measured line period in samples
//   frame_lines            last measured frame length in lines
//   lit_count              white active pixels counted in the last frame
module vga_rx_monitor #(
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int H_PULSE      = 96,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_PULSE      = 2,
    parameter int LOCK_FRAMES  = 2,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic        clk_50mhz,
    input  logic        reset_n,
    input  logic        pix_ce,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        de,
    output logic        locked,
    output logic        timing_err,
    output logic        frame_done,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic [18:0] lit_count
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRACK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [9:0] HT    = 10'(H_TOTAL);
    localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] HSS   = 10'(H_SYNC_START);
    localparam logic [9:0] HP    = 10'(H_PULSE);
    localparam logic [9:0] VT    = 10'(V_TOTAL);
    localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] VSS   = 10'(V_SYNC_START);
    localparam logic [9:0] VP    = 10'(V_PULSE);
    localparam logic [9:0] HA    = 10'(H_ACTIVE);
    localparam logic [9:0] VA    = 10'(V_ACTIVE);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    logic        hs_prev, vs_prev;
    logic        h_seen, v_seen;     // a fall has been seen since reset, so measurements are meaningful
    logic [9:0]  h_cnt, hp_cnt, v_cnt, vp_cnt;
    logic [1:0]  state, state_next;
    logic [7:0]  good_cnt, good_next;
    logic        frame_bad, bad_next; // current frame already had an error and cannot count as good
    logic [18:0] lit_cnt;
    logic [9:0]  x_next, y_next;
    logic        h_fall, h_rise, v_fall, v_rise, err_now, de_next, white;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign h_fall = pix_ce & hs_prev & ~hsync;
    assign h_rise = pix_ce & ~hs_prev & hsync;
    assign v_fall = pix_ce & vs_prev & ~vsync;
    assign v_rise = pix_ce & ~vs_prev & vsync;
    assign white  = (red == 4'hF) && (green == 4'hF) && (blue == 4'hF);

    assign err_now = (h_fall & h_seen & (h_cnt != HT))
                   | (h_rise & h_seen & (hp_cnt != HP))
                   | (v_fall & v_seen & (v_cnt != VT))
                   | (v_rise & v_seen & (vp_cnt != VP));

    assign locked = (state == LOCKED);
    assign de     = locked && (pixel_x < HA) && (pixel_y < VA);

    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (h_fall) begin
            x_next = HSS;
        end else if (pixel_x == HT_M1) begin
            x_next = 10'd0;
            y_next = (pixel_y == VT_M1) ? 10'd0 : pixel_y + 10'd1;
        end else begin
            x_next = pixel_x + 10'd1;
        end
        if (v_fall) begin
            y_next = VSS;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = frame_bad;
        if (err_now) begin
            // An error coinciding with a vsync fall belongs to the frame just ending.
            state_next = (state != SEARCH || v_fall) ? TRACK : SEARCH;
            good_next  = 8'd0;
            bad_next   = ~v_fall;
        end else if (v_fall) begin
            bad_next = 1'b0;
            case (state)
                SEARCH: begin
                    state_next = TRACK;
                    good_next  = 8'd0;
                end
                TRACK: begin
                    if (!frame_bad) begin
                        good_next = good_cnt + 8'd1;
                        if ((good_cnt + 8'd1) >= LOCK_N) begin
                            state_next = LOCKED;
                        end
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // de of the sample being taken this edge, used to qualify white-pixel counting.
    assign de_next = (state_next == LOCKED) && (x_next < HA) && (y_next < VA);

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            h_seen      <= 1'b0;
            v_seen      <= 1'b0;
            h_cnt       <= 10'd0;
            hp_cnt      <= 10'd0;
            v_cnt       <= 10'd0;
            vp_cnt      <= 10'd0;
            state       <= SEARCH;
            good_cnt    <= 8'd0;
            frame_bad   <= 1'b0;
            lit_cnt     <= 19'd0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            timing_err  <= 1'b0;
            frame_done  <= 1'b0;
            line_len    <= 10'd0;
            frame_lines <= 10'd0;
            lit_count   <= 19'd0;
        end else begin
            // Pulses are qualified by pix_ce through the edge detects, so they last one clock.
            timing_err <= err_now;
            frame_done <= v_fall;
            if (pix_ce) begin
                hs_prev   <= hsync;
                vs_prev   <= vsync;
                pixel_x   <= x_next;
                pixel_y   <= y_next;
                state     <= state_next;
                good_cnt  <= good_next;
                frame_bad <= bad_next;

                // The fall sample starts the next line and the low pulse.
                if (h_fall) begin
                    line_len <= h_cnt;
                    h_cnt    <= 10'd1;
                    hp_cnt   <= 10'd1;
                    h_seen   <= 1'b1;
                end else begin
                    h_cnt <= sat_inc(h_cnt);
                    if (!hsync) begin
                        hp_cnt <= sat_inc(hp_cnt);
                    end
                end

                // Vertical measurements count hsync falls, not samples.
                if (v_fall) begin
                    frame_lines <= v_cnt;
                    v_cnt       <= h_fall ? 10'd1 : 10'd0;
                    vp_cnt      <= h_fall ? 10'd1 : 10'd0;
                    v_seen      <= 1'b1;
                    lit_count   <= lit_cnt;
                    lit_cnt     <= 19'd0;
                end else begin
                    if (h_fall) begin
                        v_cnt <= sat_inc(v_cnt);
                        if (!vsync) begin
                            vp_cnt <= sat_inc(vp_cnt);
                        end
                    end
                    if (de_next && white) begin
                        lit_cnt <= lit_cnt + 19'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixels per line.
REQ-002 SHALL have parameter H_SYNC_START, default 656, pixel position of the first hsync-low sample.
REQ-003 SHALL have parameter H_PULSE, default 96, hsync low width in pixels.
REQ-004 SHALL have parameter V_TOTAL, default 525, lines per frame; V_SYNC_START, default 490, line of the first vsync-low sample; V_PULSE, default 2, vsync low width in lines.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames needed for lock.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk_50mhz  input  1  rising-edge clock; reset_n  input  1  async reset, active low.
REQ-007 SHALL have pix_ce  input  1  pixel sample strobe (one clk_50mhz cycle in two).
REQ-008 SHALL have hsync, vsync  input  1 each  active-low syncs; red, green, blue  input  4 each  pixel colour.
REQ-009 SHALL have pixel_x, pixel_y  output  10 each  recovered position of the last sample.
REQ-010 SHALL have de  output  1  recovered active video; locked  output  1  timing lock.
REQ-011 SHALL have timing_err  output  1  one-cycle error pulse; frame_done  output  1  one-cycle pulse at each vsync fall.
REQ-012 SHALL have line_len  output  10  last measured line period; frame_lines  output  10  last measured lines per frame; lit_count  output  19  white active pixels in the last frame.

Function
REQ-013 SHALL sample all inputs only on clk_50mhz edges with pix_ce=1; all state SHALL hold when pix_ce=0.
REQ-014 SHALL detect an hsync fall as sampled hsync=0 with previous sample 1, and a vsync fall the same way.
REQ-015 SHALL update pixel_x, pixel_y, de on the same edge as the sample they describe (latency 1 clk).
REQ-016 On an hsync fall, pixel_x SHALL load H_SYNC_START; otherwise pixel_x SHALL increment and wrap H_TOTAL-1 -> 0, with pixel_y incrementing on wrap and itself wrapping V_TOTAL-1 -> 0.
REQ-017 On a vsync fall, pixel_y SHALL load V_SYNC_START; the vsync load SHALL take priority over the pixel_y increment; simultaneous hsync and vsync falls SHALL both apply.
REQ-018 de SHALL equal locked AND pixel_x<640 AND pixel_y<480.
REQ-019 line_len SHALL load, on each hsync fall, the sample count from the previous hsync fall inclusive to this fall exclusive, saturating at 1023.
REQ-020 The hsync low width SHALL be counted in samples and checked on the hsync rise; the vsync low width SHALL be counted in hsync falls and checked on the vsync rise.
REQ-021 frame_lines SHALL load, on each vsync fall, the count of hsync falls since the previous vsync fall, saturating at 1023.
REQ-022 timing_err SHALL pulse for one cycle when any completed measurement differs from H_TOTAL, H_PULSE, V_TOTAL or V_PULSE; measurements SHALL be checked only after the first fall of the relevant sync since reset.
REQ-023 Lock FSM states: SEARCH, TRACK, LOCKED. The first vsync fall after reset SHALL move SEARCH->TRACK and clear the good-frame count.
REQ-024 In TRACK, each error-free frame ending at a vsync fall SHALL increment the good-frame count; reaching LOCK_FRAMES SHALL enter LOCKED with locked=1 on that edge.
REQ-025 Any timing_err SHALL, on that edge, move TRACK or LOCKED to TRACK, clear the good-frame count, and drop locked.
REQ-026 lit_count SHALL count samples with de=1 and red=green=blue=4'hF, load the count on each vsync fall, and then restart from zero; frame_done SHALL pulse on that same edge.

Reset
REQ-027 While reset_n=0, all outputs SHALL be 0, the FSM SHALL be in SEARCH, and all counters and previous-sample registers SHALL be 1 (syncs) or 0 (others).
REQ-028 Reset asserted mid-frame SHALL clear state immediately; relock SHALL require a full fresh SEARCH->TRACK->LOCKED sequence.

Verification
REQ-029 Three clean 640x480 frames from reset -> locked rises on the third vsync-fall edge; line_len=800; frame_lines=525; timing_err never asserted.
REQ-030 Locked stream with white 1-pixel rectangle outline x 53..242, y 24..96 -> lit_count=522 at the next frame_done.
REQ-031 Locked stream, one line shortened to 799 pixels -> timing_err pulses at the next hsync fall, locked=0; locked returns after 2 further clean frames.
REQ-032 hsync low for 95 samples -> timing_err pulses on the hsync rise.
REQ-033 reset_n pulsed low mid-frame while locked -> all outputs 0; locked is regained on the third vsync fall after release.
REQ-034 pix_ce held 0 for 100 clocks mid-line -> pixel_x, counters and lit_count are unchanged; no timing_err occurs.
